// File: rtl/tmds_rx_decoder_pkg.sv
// Shared TMDS receive definitions: control token words, FSM states and the token matcher.
// The transmit encoder uses the same token constants.
package tmds_rx_decoder_pkg;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] ctrl;
    } tok_match_t;

    function automatic tok_match_t tok_match(input logic [9:0] word);
        tok_match_t m;
        m.hit  = 1'b1;
        m.ctrl = 2'b00;
        case (word)
            TOK_C00: m.ctrl = 2'b00;
            TOK_C01: m.ctrl = 2'b01;
            TOK_C10: m.ctrl = 2'b10;
            TOK_C11: m.ctrl = 2'b11;
            default: m.hit  = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Stage-2 registered TMDS word decode: control token match plus inversion and XOR/XNOR undo.
// ctrl holds the last token's value while data words pass through.
module tmds_word_decode
    import tmds_rx_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] word,
    output logic       is_token,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    tok_match_t tm;
    logic [7:0] q;
    logic [7:0] dec;

    assign tm = tok_match(word);

    always_comb begin
        q      = word[9] ? ~word[7:0] : word[7:0];
        dec    = '0;
        dec[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = word[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
    end

    // Reset presents as a control token so the derived de starts low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_token <= 1'b1;
            ctrl     <= 2'b00;
            data     <= 8'h00;
        end else if (tm.hit) begin
            is_token <= 1'b1;
            ctrl     <= tm.ctrl;
            data     <= 8'h00;
        end else begin
            is_token <= 1'b0;
            data     <= dec;
        end
    end

endmodule

// File: rtl/tmds_rx_decoder.sv
// TMDS receive channel: word alignment by bit-slip search on control tokens, lock tracking,
// and a two-stage registered decode of video data, control bits and DE.
module tmds_rx_decoder
    import tmds_rx_decoder_pkg::*;
#(
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_SETTLE    = 8,
    parameter int LOCK_TOKENS    = 12,
    parameter int LOSS_TIMEOUT   = 65536
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic [9:0] din,
    output logic       bitslip,
    output logic       aligned,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data,
    output logic [3:0] slip_count
);

    localparam int MISS_MAX = (LOSS_TIMEOUT > SEARCH_TIMEOUT) ? LOSS_TIMEOUT : SEARCH_TIMEOUT;
    localparam int MISS_W   = $clog2(MISS_MAX) + 1;
    localparam int TOK_W    = $clog2(LOCK_TOKENS) + 1;
    localparam int SET_W    = $clog2(SLIP_SETTLE) + 1;

    localparam logic [MISS_W-1:0] SRCH_LAST = MISS_W'(SEARCH_TIMEOUT - 1);
    localparam logic [MISS_W-1:0] LOSS_LAST = MISS_W'(LOSS_TIMEOUT - 1);
    localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_TOKENS - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SLIP_SETTLE - 1);

    rx_state_e         state, state_nxt;
    logic [9:0]        din_r;
    logic [MISS_W-1:0] miss_cnt, miss_nxt;
    logic [TOK_W-1:0]  tok_cnt, tok_nxt;
    logic [SET_W-1:0]  set_cnt, set_nxt;
    logic [3:0]        slip_nxt;
    logic              is_token;
    tok_match_t        tm;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) din_r <= '0;
        else        din_r <= din;
    end

    tmds_word_decode u_dec (
        .clk      (clkin),
        .rst_n    (rst_n),
        .word     (din_r),
        .is_token (is_token),
        .ctrl     (ctrl),
        .data     (data)
    );

    assign de = ~is_token;
    assign tm = tok_match(din_r);

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_SEARCH;
            miss_cnt   <= '0;
            tok_cnt    <= '0;
            set_cnt    <= '0;
            slip_count <= '0;
        end else begin
            state      <= state_nxt;
            miss_cnt   <= miss_nxt;
            tok_cnt    <= tok_nxt;
            set_cnt    <= set_nxt;
            slip_count <= slip_nxt;
        end
    end

    // Counters compare against the last legal value and clear, so they never wrap.
    always_comb begin
        state_nxt = state;
        miss_nxt  = miss_cnt;
        tok_nxt   = tok_cnt;
        set_nxt   = set_cnt;
        slip_nxt  = slip_count;
        case (state)
            ST_SEARCH: begin
                if (tm.hit) begin
                    miss_nxt = '0;
                    tok_nxt  = tok_cnt + 1'b1;
                    if (tok_cnt == TOK_LAST) state_nxt = ST_LOCKED;
                end else if (miss_cnt == SRCH_LAST) begin
                    state_nxt = ST_SLIP;
                    miss_nxt  = '0;
                    tok_nxt   = '0;
                end else begin
                    miss_nxt = miss_cnt + 1'b1;
                    tok_nxt  = '0;
                end
            end
            ST_SLIP: begin
                state_nxt = ST_SETTLE;
                miss_nxt  = '0;
                tok_nxt   = '0;
                set_nxt   = '0;
                if (slip_count != 4'hF) slip_nxt = slip_count + 1'b1;
            end
            ST_SETTLE: begin
                if (set_cnt == SET_LAST) begin
                    state_nxt = ST_SEARCH;
                    set_nxt   = '0;
                end else begin
                    set_nxt = set_cnt + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (tm.hit) begin
                    miss_nxt = '0;
                end else if (miss_cnt == LOSS_LAST) begin
                    state_nxt = ST_SEARCH;
                    miss_nxt  = '0;
                    tok_nxt   = '0;
                    slip_nxt  = '0;
                end else begin
                    miss_nxt = miss_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    // Decoded straight from the state register so an async reset drops them at once.
    assign bitslip = (state == ST_SLIP);
    assign aligned = (state == ST_LOCKED);

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Randomized bench for tmds_rx_decoder: token/lock model with a two-word output lag,
// reference TMDS encoder for data round trips, and a bit-serial deserializer that honours bitslip.
module tb_tmds_rx_decoder;

    localparam int ST = 64;
    localparam int SS = 8;
    localparam int LT = 12;
    localparam int LO = 300;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic       bitslip;
    logic       aligned;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [3:0] slip_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       chk;
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
        logic       aligned;
    } exp_t;

    exp_t expq[$];

    // Behavioural lock model
    logic       m_locked;
    int         m_tc;
    int         m_mc;
    logic [1:0] m_ctrl;

    // Deserializer stream content
    logic [7:0] s_byte[32];
    logic       s_inv[32];

    tmds_rx_decoder #(
        .SEARCH_TIMEOUT (ST),
        .SLIP_SETTLE    (SS),
        .LOCK_TOKENS    (LT),
        .LOSS_TIMEOUT   (LO)
    ) dut (
        .clkin      (clk),
        .rst_n      (rst_n),
        .din        (din),
        .bitslip    (bitslip),
        .aligned    (aligned),
        .de         (de),
        .ctrl       (ctrl),
        .data       (data),
        .slip_count (slip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] tok_of(input logic [9:0] w);
        case (w)
            T00:     return 3'b100;
            T01:     return 3'b101;
            T10:     return 3'b110;
            T11:     return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    // Transmit-side TMDS encoder (transition minimisation plus optional inversion)
    function automatic logic [9:0] enc(input logic [7:0] b, input logic inv);
        logic [8:0] qm;
        logic       xn;
        int         n;
        n     = $countones(b);
        xn    = (n > 4) || (n == 4 && b[0] == 1'b0);
        qm    = '0;
        qm[0] = b[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
        qm[8] = ~xn;
        return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    endfunction

    function automatic logic [9:0] stream_word(input int n);
        int k;
        k = n % 32;
        if (k < 20) return T00;
        return enc(s_byte[k], s_inv[k]);
    endfunction

    // Word seen by the receiver when the boundary sits 'off' bits into the serial stream.
    function automatic logic [9:0] des_word(input int w, input int off);
        logic [9:0] r;
        logic [9:0] sw;
        int         p;
        r = '0;
        for (int j = 0; j < 10; j++) begin
            p    = 10 * w + off + j;
            sw   = stream_word(p / 10);
            r[j] = sw[p % 10];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_tc     = 0;
        m_mc     = 0;
        m_ctrl   = 2'b00;
        expq.delete();
        expq.push_back('{chk: 1'b0, de: 1'b0, ctrl: 2'b00, data: 8'h00, aligned: 1'b0});
    endtask

    task automatic send(input logic [9:0] w, input logic [7:0] byte_exp);
        exp_t       e;
        exp_t       h;
        logic [2:0] t;
        t   = tok_of(w);
        din = w;
        if (t[2]) m_ctrl = t[1:0];
        if (!m_locked) begin
            if (t[2]) begin
                m_tc++;
                if (m_tc == LT) begin
                    m_locked = 1'b1;
                    m_mc     = 0;
                end
            end else begin
                m_tc = 0;
            end
        end else if (t[2]) begin
            m_mc = 0;
        end else begin
            m_mc++;
            if (m_mc == LO) begin
                m_locked = 1'b0;
                m_tc     = 0;
                m_mc     = 0;
            end
        end
        e.chk     = 1'b1;
        e.de      = ~t[2];
        e.ctrl    = m_ctrl;
        e.data    = t[2] ? 8'h00 : byte_exp;
        e.aligned = m_locked;
        expq.push_back(e);
        @(posedge clk);
        #1;
        h = expq.pop_front();
        if (h.chk) begin
            check("de", 32'(de), 32'(h.de));
            check("ctrl", 32'(ctrl), 32'(h.ctrl));
            check("data", 32'(data), 32'(h.data));
            check("aligned", 32'(aligned), 32'(h.aligned));
            check("bitslip_idle", 32'(bitslip), 32'd0);
            check("slip_count_idle", 32'(slip_count), 32'd0);
        end
    endtask

    task automatic send_data();
        logic [7:0] b;
        b = 8'($urandom);
        send(enc(b, 1'($urandom_range(0, 1))), b);
    endtask

    function automatic logic [9:0] rand_tok();
        case ($urandom_range(0, 3))
            0:       return T00;
            1:       return T01;
            2:       return T10;
            default: return T11;
        endcase
    endfunction

    initial begin
        int         off;
        int         w;
        int         slips;
        int         last_pulse;
        int         min_gap;
        logic       wide;
        logic       prev_bs;
        logic       seen;

        for (int i = 0; i < 32; i++) begin
            s_byte[i] = 8'($urandom);
            s_inv[i]  = 1'($urandom_range(0, 1));
        end

        // Reset held with random input
        rst_n = 1'b0;
        din   = '0;
        repeat (8) begin
            din = 10'($urandom);
            @(posedge clk);
            #1;
            check("rst_bitslip", 32'(bitslip), 32'd0);
            check("rst_aligned", 32'(aligned), 32'd0);
            check("rst_de", 32'(de), 32'd0);
            check("rst_ctrl", 32'(ctrl), 32'd0);
            check("rst_data", 32'(data), 32'd0);
            check("rst_slip_count", 32'(slip_count), 32'd0);
        end

        // Aligned stream: lock on 12 tokens, then video data
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < LT; i++) send(T00, 8'h00);
        for (int i = 0; i < 20; i++) send_data();
        check("lock_aligned", 32'(aligned), 32'd1);

        // Directed decode; XNOR of identical bits yields ones above bit 0
        send(10'b0100000000, 8'h00);
        send(10'b1011111111, 8'hFE);

        // All 256 bytes through the reference encoder, random tokens interleaved
        for (int i = 0; i < 256; i++) begin
            if (i % 32 == 0) send(rand_tok(), 8'h00);
            send(enc(8'(i), 1'($urandom_range(0, 1))), 8'(i));
        end

        // Loss of lock: a token just before the timeout keeps lock, a full run drops it
        send(T00, 8'h00);
        for (int i = 0; i < LO - 1; i++) send_data();
        send(T10, 8'h00);
        for (int i = 0; i < LO - 1; i++) send_data();
        send_data();
        check("loss_keep", 32'(aligned), 32'd1);
        send_data();
        send_data();
        check("loss_drop", 32'(aligned), 32'd0);

        // Misaligned by 3 bits: needs three slips
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        off        = 7;
        w          = 0;
        slips      = 0;
        last_pulse = -1000;
        min_gap    = 1000;
        wide       = 1'b0;
        prev_bs    = 1'b0;
        seen       = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            din = des_word(w, off);
            w++;
            @(posedge clk);
            #1;
            if (bitslip) begin
                if (prev_bs) wide = 1'b1;
                if (slips > 0 && (cyc - last_pulse - 1) < min_gap) min_gap = cyc - last_pulse - 1;
                slips++;
                last_pulse = cyc;
                off++;
            end
            prev_bs = bitslip;
            if (aligned) seen = 1'b1;
        end
        check("mis_lock_seen", 32'(seen), 32'd1);
        check("mis_slips", 32'(slips), 32'd3);
        check("mis_wide_pulse", 32'(wide), 32'd0);
        check("mis_gap_ok", 32'(min_gap >= SS + 1), 32'd1);
        check("mis_slip_count", 32'(slip_count), 32'd3);
        for (int i = 0; i < 64; i++) begin
            din = des_word(w, off);
            w++;
            @(posedge clk);
            #1;
        end
        check("mis_hold_aligned", 32'(aligned), 32'd1);
        check("mis_ctrl", 32'(ctrl), 32'd0);
        check("mis_slip_count_hold", 32'(slip_count), 32'd3);

        // Async reset during the bitslip pulse
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        off  = 7;
        w    = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 1000 && !seen; cyc++) begin
            din = des_word(w, off);
            w++;
            @(posedge clk);
            #1;
            if (bitslip) seen = 1'b1;
        end
        check("ar_pulse_seen", 32'(seen), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_bitslip", 32'(bitslip), 32'd0);
        check("ar_aligned", 32'(aligned), 32'd0);
        check("ar_slip_count", 32'(slip_count), 32'd0);
        check("ar_de", 32'(de), 32'd0);
        check("ar_data", 32'(data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int cyc = 0; cyc < 1000 && !seen; cyc++) begin
            din = des_word(w, off);
            w++;
            @(posedge clk);
            #1;
            if (bitslip) seen = 1'b1;
        end
        check("ar_restart_pulse", 32'(seen), 32'd1);
        check("ar_restart_count0", 32'(slip_count), 32'd0);
        din = des_word(w, off + 1);
        @(posedge clk);
        #1;
        check("ar_restart_count1", 32'(slip_count), 32'd1);
        check("ar_restart_bitslip_low", 32'(bitslip), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
